board_io_ctrl: RTL

- Parametrised board-level user-I/O block for the sys0 domain.
- Synchronises and debounces N dip switches and drives M LEDs, each from a per-LED mode register.
- Modes: off, on, shared blink, follow debounced switch.
- Sits beside the FTop instance in each board top; replaces direct usr_sw/led wiring with a reusable, board-width-independent block.

---
 rtl/board_io_ctrl_if.sv | 28 ++
 rtl/board_io_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/board_io_ctrl_if.sv
// Bus interface for board_io_ctrl: switch inputs/outputs, LED mode-write port,
// mode readback and LED pins. The master modport is the controlling side
// (board logic or bench); the slave modport is the board_io_ctrl block.
interface board_io_ctrl_if #(
  parameter int NUM_SW  = 8,
  parameter int NUM_LED = 8
);
  localparam int SEL_W = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;

  logic [NUM_SW-1:0]    usr_sw_i;
  logic [NUM_SW-1:0]    sw_db;
  logic                 sw_chg;
  logic                 led_wr;
  logic [SEL_W-1:0]     led_sel;
  logic [1:0]           led_mode;
  logic [2*NUM_LED-1:0] led_mode_q;
  logic [NUM_LED-1:0]   led;

  modport master (
    output usr_sw_i, led_wr, led_sel, led_mode,
    input  sw_db, sw_chg, led_mode_q, led
  );

  modport slave (
    input  usr_sw_i, led_wr, led_sel, led_mode,
    output sw_db, sw_chg, led_mode_q, led
  );
endinterface

// File: rtl/board_io_ctrl.sv
// Board-level user-I/O block for the sys0 domain.
// Synchronises and debounces NUM_SW dip switches and drives NUM_LED LEDs, each
// from a 2-bit mode register: 0 off, 1 on, 2 shared blink, 3 follow the
// debounced switch (led i follows sw_db[i % NUM_SW]).
// Optional feature macro: BOARD_IO_HEARTBEAT_EN -- when defined, LED NUM_LED-1
// is driven by a heartbeat (lit for one prescaler period out of four) and its
// mode register only reads back without affecting the pin.
module board_io_ctrl #(
  parameter int NUM_SW         = 8,
  parameter int NUM_LED        = 8,
  parameter int DEB_CYCLES     = 1000000,
  parameter int BLINK_DIV      = 25000000,
  parameter int LED_ACTIVE_LOW = 0
) (
  input logic           sys0_clk,
  input logic           sys0_rstn,
  board_io_ctrl_if.slave bus
);

  localparam int   CNT_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int   PRE_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int   SEL_W  = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;
  localparam logic ACT_LO = (LED_ACTIVE_LOW != 0);

  // Two-stage synchroniser; sync_p1 is the synchronised switch value.
  logic [NUM_SW-1:0] sync_p0;
  logic [NUM_SW-1:0] sync_p1;

  // Clock raw switches through the two synchroniser stages.
  always_ff @(posedge sys0_clk or negedge sys0_rstn) begin
    if (!sys0_rstn) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= bus.usr_sw_i;
      sync_p1 <= sync_p0;
    end
  end

  // ---- debounce stage ----
  logic [NUM_SW-1:0] db_q;
  logic [NUM_SW-1:0] upd;
  logic              chg_q;

  for (genvar i = 0; i < NUM_SW; i++) begin : g_deb
    logic [CNT_W-1:0] cnt;

    // A switch is accepted once it has differed from sw_db for DEB_CYCLES
    // consecutive synchronised cycles.
    assign upd[i] = (sync_p1[i] != db_q[i]) && (cnt == CNT_W'(DEB_CYCLES - 1));

    // Count consecutive cycles of disagreement; any agreement restarts it.
    always_ff @(posedge sys0_clk or negedge sys0_rstn) begin
      if (!sys0_rstn) begin
        cnt <= '0;
      end else if (sync_p1[i] == db_q[i] || upd[i]) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Flip the bits that qualified (upd implies sync != db, so xor loads sync);
  // sw_chg is a single pulse however many switches moved together.
  always_ff @(posedge sys0_clk or negedge sys0_rstn) begin
    if (!sys0_rstn) begin
      db_q  <= '0;
      chg_q <= 1'b0;
    end else begin
      db_q  <= db_q ^ upd;
      chg_q <= |upd;
    end
  end

  // ---- blink timebase ----
  logic [PRE_W-1:0] pre;
  logic             wrap;
  logic             blink_phase;

  assign wrap = (pre == PRE_W'(BLINK_DIV - 1));

  // Prescaler wraps every BLINK_DIV cycles; the blink phase toggles on wrap.
  always_ff @(posedge sys0_clk or negedge sys0_rstn) begin
    if (!sys0_rstn) begin
      pre         <= '0;
      blink_phase <= 1'b0;
    end else if (wrap) begin
      pre         <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      pre         <= pre + PRE_W'(1);
    end
  end

  // ---- mode registers ----
  logic [2*NUM_LED-1:0] mode_q;
  logic [31:0]          sel_ext;
  logic                 wr_ok;

  assign sel_ext = 32'(bus.led_sel);
  assign wr_ok   = bus.led_wr && (sel_ext < 32'(NUM_LED));

  // Write the addressed LED mode; out-of-range indices are dropped.
  always_ff @(posedge sys0_clk or negedge sys0_rstn) begin
    if (!sys0_rstn) begin
      mode_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LED; i++) begin
        if (wr_ok && sel_ext == 32'(i)) begin
          mode_q[2*i +: 2] <= bus.led_mode;
        end
      end
    end
  end

  // ---- LED output stage ----
  logic [NUM_LED-1:0] lit;
  logic [NUM_LED-1:0] lit_out;
  logic [NUM_LED-1:0] led_q;

  // Decode each LED's mode into an active-high lit request.
  always_comb begin
    lit = '0;
    for (int i = 0; i < NUM_LED; i++) begin
      case (mode_q[2*i +: 2])
        2'd1:    lit[i] = 1'b1;
        2'd2:    lit[i] = blink_phase;
        2'd3:    lit[i] = db_q[i % NUM_SW];
        default: lit[i] = 1'b0;
      endcase
    end
  end

`ifdef BOARD_IO_HEARTBEAT_EN
  logic [1:0] hb_cnt;

  // Heartbeat phase advances once per prescaler wrap (four-period window).
  always_ff @(posedge sys0_clk or negedge sys0_rstn) begin
    if (!sys0_rstn) begin
      hb_cnt <= 2'd0;
    end else if (wrap) begin
      hb_cnt <= hb_cnt + 2'd1;
    end
  end

  // Last LED shows the heartbeat instead of its mode decode.
  always_comb begin
    lit_out              = lit;
    lit_out[NUM_LED-1]   = (hb_cnt == 2'd0);
  end
`else
  assign lit_out = lit;
`endif

  // Register the pins with board polarity applied; reset leaves them dark.
  always_ff @(posedge sys0_clk or negedge sys0_rstn) begin
    if (!sys0_rstn) begin
      led_q <= {NUM_LED{ACT_LO}};
    end else begin
      led_q <= lit_out ^ {NUM_LED{ACT_LO}};
    end
  end

  assign bus.sw_db      = db_q;
  assign bus.sw_chg     = chg_q;
  assign bus.led_mode_q = mode_q;
  assign bus.led        = led_q;

endmodule
